// File: rtl/histogram_pkg.sv
// Shared defaults, typedefs and the completion-tracker state encoding for histogram2.
package histogram_pkg;

    localparam int DEFAULT_PIXEL_W     = 10;
    localparam int DEFAULT_NUM_BINS    = 1 << DEFAULT_PIXEL_W;
    localparam int DEFAULT_BUCKET_SIZE = 24;

    // Cycles after image_done is seen before histo_done may rise.
    localparam logic [1:0] DONE_DELAY = 2'd3;

    typedef logic [DEFAULT_PIXEL_W-1:0]     bin_idx_t;
    typedef logic [DEFAULT_BUCKET_SIZE-1:0] count_t;

    typedef enum logic [1:0] {
        DONE_IDLE,
        DONE_DRAIN,
        DONE_READY
    } done_state_t;

endpackage

// File: rtl/histo_bin_ram.sv
// Simple dual-port bin storage with one synchronous read port and one write port.
// A read that coincides with a write to the same address returns the old word.
module histo_bin_ram
    import histogram_pkg::*;
#(
    parameter int DEPTH  = DEFAULT_NUM_BINS,
    parameter int ADDR_W = DEFAULT_PIXEL_W,
    parameter int DATA_W = DEFAULT_BUCKET_SIZE
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/histogram2.sv
// 1024-bin pixel histogram: 3-stage read-modify-write accumulate with S2->S1 forwarding.
// Optional macro HISTO_SATURATE_EN makes bins saturate instead of wrapping.
module histogram2
    import histogram_pkg::*;
#(
    parameter int NUM_BINS          = DEFAULT_NUM_BINS,
    parameter int PIXEL_W           = DEFAULT_PIXEL_W,
    parameter int HISTO_BUCKET_SIZE = DEFAULT_BUCKET_SIZE
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [PIXEL_W-1:0]           pixel,
    input  logic                         pixel_valid,
    input  logic                         rw,
    input  logic                         image_done,
    input  logic [PIXEL_W-1:0]           bin,
    output logic [HISTO_BUCKET_SIZE-1:0] data,
    output logic                         histo_done
);

    logic                         s0_valid;
    logic [PIXEL_W-1:0]           s0_pixel;
    logic                         s1_valid;
    logic [PIXEL_W-1:0]           s1_addr;
    logic                         s2_valid;
    logic [PIXEL_W-1:0]           s2_addr;
    logic [HISTO_BUCKET_SIZE-1:0] s2_count;
    logic [NUM_BINS-1:0]          valid_vec;
    logic [PIXEL_W-1:0]           rd_addr;
    logic [HISTO_BUCKET_SIZE-1:0] rd_q;
    logic                         rd_vld;
    logic [HISTO_BUCKET_SIZE-1:0] rd_bin_count;
    logic [HISTO_BUCKET_SIZE-1:0] base_count;
    logic [HISTO_BUCKET_SIZE-1:0] next_count;
    logic                         pipe_empty;
    logic                         read_en;
    logic                         read_phase;
    logic [HISTO_BUCKET_SIZE-1:0] data_hold;
    done_state_t                  done_state;
    logic [1:0]                   done_cnt;

    assign pipe_empty = !s0_valid && !s1_valid;
    assign read_en    = !rw && pipe_empty;
    assign rd_addr    = read_en ? bin : s0_pixel;

    histo_bin_ram #(
        .DEPTH  (NUM_BINS),
        .ADDR_W (PIXEL_W),
        .DATA_W (HISTO_BUCKET_SIZE)
    ) u_ram (
        .clk   (clk),
        .we    (s1_valid),
        .waddr (s1_addr),
        .wdata (next_count),
        .raddr (rd_addr),
        .rdata (rd_q)
    );

    // A bin never written since reset reads as zero, whatever the RAM holds.
    always_comb begin
        rd_bin_count = rd_vld ? rd_q : '0;
        base_count   = (s2_valid && (s2_addr == s1_addr)) ? s2_count : rd_bin_count;
`ifdef HISTO_SATURATE_EN
        next_count = (&base_count) ? base_count : base_count + HISTO_BUCKET_SIZE'(1);
`else
        next_count = base_count + HISTO_BUCKET_SIZE'(1);
`endif
        data = read_phase ? rd_bin_count : data_hold;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s0_valid   <= 1'b0;
            s0_pixel   <= '0;
            s1_valid   <= 1'b0;
            s1_addr    <= '0;
            s2_valid   <= 1'b0;
            s2_addr    <= '0;
            s2_count   <= '0;
            valid_vec  <= '0;
            rd_vld     <= 1'b0;
            read_phase <= 1'b0;
            data_hold  <= '0;
        end else begin
            s0_valid <= rw && pixel_valid;
            s0_pixel <= pixel;
            s1_valid <= s0_valid;
            s1_addr  <= s0_pixel;
            rd_vld   <= valid_vec[rd_addr];
            s2_valid <= s1_valid;
            s2_addr  <= s1_addr;
            s2_count <= next_count;
            if (s1_valid) begin
                valid_vec[s1_addr] <= 1'b1;
            end
            read_phase <= read_en;
            if (read_phase) begin
                data_hold <= rd_bin_count;
            end
        end
    end

    // image_done is remembered once seen; histo_done follows after DONE_DELAY more edges.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            done_state <= DONE_IDLE;
            done_cnt   <= '0;
            histo_done <= 1'b0;
        end else if (rw) begin
            done_state <= DONE_IDLE;
            done_cnt   <= '0;
            histo_done <= 1'b0;
        end else begin
            case (done_state)
                DONE_IDLE: begin
                    if (image_done) begin
                        done_state <= DONE_DRAIN;
                        done_cnt   <= 2'd1;
                    end
                end
                DONE_DRAIN: begin
                    if (done_cnt != DONE_DELAY) begin
                        done_cnt <= done_cnt + 2'd1;
                    end else if (pipe_empty) begin
                        done_state <= DONE_READY;
                        histo_done <= 1'b1;
                    end
                end
                default: begin
                    histo_done <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_histogram2.sv
// Randomized self-checking bench for histogram2 against a per-bin count model.
// Runs a 24-bit instance and a 4-bit instance side by side on the same stimulus.
module tb_histogram2;
    import histogram_pkg::*;

    localparam int PW      = DEFAULT_PIXEL_W;
    localparam int CW      = DEFAULT_BUCKET_SIZE;
    localparam int NB      = DEFAULT_NUM_BINS;
    localparam int SMALL_W = 4;
    localparam int unsigned BIG_MAX   = (1 << CW) - 1;
    localparam int unsigned SMALL_MAX = (1 << SMALL_W) - 1;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [PW-1:0]      pixel = '0;
    logic               pixel_valid = 1'b0;
    logic               rw = 1'b0;
    logic               image_done = 1'b0;
    logic [PW-1:0]      bin = '0;
    logic [CW-1:0]      data;
    logic               histo_done;
    logic [SMALL_W-1:0] data_s;
    logic               done_s;

    int n_cmp = 0;
    int n_bad = 0;
    int unsigned model [NB];
    int unsigned small_model [NB];

    always #5 clk = ~clk;

    histogram2 u_dut (
        .clk         (clk),
        .rst         (rst),
        .pixel       (pixel),
        .pixel_valid (pixel_valid),
        .rw          (rw),
        .image_done  (image_done),
        .bin         (bin),
        .data        (data),
        .histo_done  (histo_done)
    );

    histogram2 #(.HISTO_BUCKET_SIZE(SMALL_W)) u_small (
        .clk         (clk),
        .rst         (rst),
        .pixel       (pixel),
        .pixel_valid (pixel_valid),
        .rw          (rw),
        .image_done  (image_done),
        .bin         (bin),
        .data        (data_s),
        .histo_done  (done_s)
    );

    function automatic int unsigned bump(int unsigned v, int unsigned maxv);
`ifdef HISTO_SATURATE_EN
        return (v == maxv) ? v : v + 1;
`else
        return (v == maxv) ? 0 : v + 1;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        for (int i = 0; i < NB; i++) begin
            model[i] = 0;
            small_model[i] = 0;
        end
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        rw = 1'b0;
        pixel_valid = 1'b0;
        image_done = 1'b0;
        tick();
        tick();
        clear_model();
        rst = 1'b1;
    endtask

    task automatic send(input logic [PW-1:0] p, input logic v);
        rw = 1'b1;
        image_done = 1'b0;
        pixel = p;
        pixel_valid = v;
        tick();
        if (v) begin
            model[p] = bump(model[p], BIG_MAX);
            small_model[p] = bump(small_model[p], SMALL_MAX);
        end
    endtask

    // Drops rw with a stray valid pixel on the same edge, then measures done latency.
    task automatic finish_frame(input logic [PW-1:0] stray, output int lat);
        rw = 1'b0;
        image_done = 1'b1;
        pixel = stray;
        pixel_valid = 1'b1;
        tick();
        pixel_valid = 1'b0;
        image_done = 1'b0;
        lat = -1;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (histo_done === 1'b1) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic read_bin(input logic [PW-1:0] b, output logic [CW-1:0] d,
                            output logic [SMALL_W-1:0] ds);
        bin = b;
        tick();
        d = data;
        ds = data_s;
    endtask

    task automatic test_reset();
        int lat;
        logic [CW-1:0] d;
        logic [SMALL_W-1:0] ds;
        logic [PW-1:0] probes [3];
        probes[0] = 10'd0;
        probes[1] = 10'd511;
        probes[2] = 10'd1023;
        rst = 1'b0;
        tick();
        n_cmp++;
        if (data !== '0 || histo_done !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL reset_outputs: data=%0d done=%0b, expected 0/0", data, histo_done);
        end
        tick();
        clear_model();
        rst = 1'b1;
        finish_frame(10'd3, lat);
        n_cmp++;
        if (lat != 3) begin
            n_bad++;
            $display("[TB] FAIL reset_done_latency: got %0d expected 3", lat);
        end
        for (int i = 0; i < 3; i++) begin
            read_bin(probes[i], d, ds);
            n_cmp++;
            if (d !== CW'(model[probes[i]])) begin
                n_bad++;
                $display("[TB] FAIL reset_bin%0d: got %0d expected %0d", probes[i], d, model[probes[i]]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [CW-1:0] d;
        logic [SMALL_W-1:0] ds;
        logic [PW-1:0] probes [3];
        probes[0] = 10'd5;
        probes[1] = 10'd7;
        probes[2] = 10'd6;
        send(10'd5, 1'b1);
        send(10'd5, 1'b1);
        send(10'd5, 1'b1);
        send(10'd7, 1'b1);
        finish_frame(10'd6, lat);
        n_cmp++;
        if (lat != 3) begin
            n_bad++;
            $display("[TB] FAIL b2b_done_latency: got %0d expected 3", lat);
        end
        for (int i = 0; i < 3; i++) begin
            read_bin(probes[i], d, ds);
            n_cmp++;
            if (d !== CW'(model[probes[i]]) || ds !== SMALL_W'(small_model[probes[i]])) begin
                n_bad++;
                $display("[TB] FAIL b2b_bin%0d: got %0d/%0d expected %0d/%0d",
                         probes[i], d, ds, model[probes[i]], small_model[probes[i]]);
            end
        end
    endtask

    task automatic test_alternating();
        int lat;
        logic [CW-1:0] d;
        logic [SMALL_W-1:0] ds;
        apply_reset();
        for (int i = 0; i < 200; i++) begin
            int gaps = $urandom_range(0, 2);
            for (int g = 0; g < gaps; g++) begin
                send(PW'($urandom), 1'b0);
            end
            send((i % 2) ? 10'd1023 : 10'd0, 1'b1);
        end
        finish_frame(10'd0, lat);
        n_cmp++;
        if (lat != 3) begin
            n_bad++;
            $display("[TB] FAIL alt_done_latency: got %0d expected 3", lat);
        end
        read_bin(10'd0, d, ds);
        n_cmp++;
        if (d !== CW'(model[0])) begin
            n_bad++;
            $display("[TB] FAIL alt_bin0: got %0d expected %0d", d, model[0]);
        end
        read_bin(10'd1023, d, ds);
        n_cmp++;
        if (d !== CW'(model[1023])) begin
            n_bad++;
            $display("[TB] FAIL alt_bin1023: got %0d expected %0d", d, model[1023]);
        end
    endtask

    task automatic test_random_frame();
        int lat;
        logic [CW-1:0] d;
        logic [SMALL_W-1:0] ds;
        for (int i = 0; i < 400; i++) begin
            logic [PW-1:0] p;
            p = ($urandom_range(0, 3) == 0) ? PW'($urandom) : PW'($urandom_range(0, 7));
            send(p, $urandom_range(0, 3) != 0);
        end
        finish_frame(10'd1, lat);
        n_cmp++;
        if (lat != 3) begin
            n_bad++;
            $display("[TB] FAIL rand_done_latency: got %0d expected 3", lat);
        end
        for (int b = 0; b < NB; b++) begin
            read_bin(PW'(b), d, ds);
            n_cmp++;
            if (d !== CW'(model[b]) || ds !== SMALL_W'(small_model[b])) begin
                n_bad++;
                $display("[TB] FAIL rand_bin%0d: got %0d/%0d expected %0d/%0d",
                         b, d, ds, model[b], small_model[b]);
            end
        end
    endtask

    task automatic test_rw_ignored();
        int lat;
        logic [CW-1:0] d;
        logic [SMALL_W-1:0] ds;
        logic [CW-1:0] held;
        rw = 1'b0;
        for (int i = 0; i < 10; i++) begin
            pixel = PW'($urandom_range(0, 7));
            pixel_valid = 1'b1;
            tick();
        end
        pixel_valid = 1'b0;
        for (int b = 0; b < 8; b++) begin
            read_bin(PW'(b), d, ds);
            n_cmp++;
            if (d !== CW'(model[b])) begin
                n_bad++;
                $display("[TB] FAIL ignored_bin%0d: got %0d expected %0d", b, d, model[b]);
            end
        end
        held = CW'(model[7]);
        n_cmp++;
        if (histo_done !== 1'b1) begin
            n_bad++;
            $display("[TB] FAIL done_before_rw: got %0b expected 1", histo_done);
        end
        send(10'd7, 1'b0);
        n_cmp++;
        if (histo_done !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL done_after_rw: got %0b expected 0", histo_done);
        end
        send(10'd7, 1'b1);
        send(10'd7, 1'b1);
        send(10'd7, 1'b1);
        n_cmp++;
        if (data !== held) begin
            n_bad++;
            $display("[TB] FAIL data_hold: got %0d expected %0d", data, held);
        end
        finish_frame(10'd7, lat);
        read_bin(10'd7, d, ds);
        n_cmp++;
        if (d !== CW'(model[7])) begin
            n_bad++;
            $display("[TB] FAIL refill_bin7: got %0d expected %0d", d, model[7]);
        end
    endtask

    task automatic test_reset_mid_frame();
        int lat;
        logic [CW-1:0] d;
        logic [SMALL_W-1:0] ds;
        apply_reset();
        for (int i = 0; i < 50; i++) begin
            send(10'd9, 1'b1);
        end
        pixel_valid = 1'b0;
        rst = 1'b0;
        tick();
        n_cmp++;
        if (histo_done !== 1'b0 || data !== '0) begin
            n_bad++;
            $display("[TB] FAIL midreset_outputs: done=%0b data=%0d expected 0/0", histo_done, data);
        end
        tick();
        clear_model();
        rst = 1'b1;
        finish_frame(10'd9, lat);
        n_cmp++;
        if (lat != 3) begin
            n_bad++;
            $display("[TB] FAIL midreset_done_latency: got %0d expected 3", lat);
        end
        read_bin(10'd9, d, ds);
        n_cmp++;
        if (d !== CW'(model[9]) || ds !== SMALL_W'(small_model[9])) begin
            n_bad++;
            $display("[TB] FAIL midreset_bin9: got %0d/%0d expected %0d/%0d", d, ds, model[9], small_model[9]);
        end
    endtask

    task automatic test_saturate();
        int lat;
        logic [CW-1:0] d;
        logic [SMALL_W-1:0] ds;
        apply_reset();
        for (int i = 0; i < 20; i++) begin
            send(10'd3, 1'b1);
        end
        finish_frame(10'd3, lat);
        read_bin(10'd3, d, ds);
        n_cmp++;
        if (d !== CW'(model[3])) begin
            n_bad++;
            $display("[TB] FAIL wide_bin3: got %0d expected %0d", d, model[3]);
        end
        n_cmp++;
        if (ds !== SMALL_W'(small_model[3])) begin
            n_bad++;
            $display("[TB] FAIL narrow_bin3: got %0d expected %0d", ds, small_model[3]);
        end
    endtask

    initial begin
        #2;
        test_reset();
        test_back_to_back();
        test_alternating();
        test_random_frame();
        test_rw_ignored();
        test_reset_mid_frame();
        test_saturate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
